// File: rtl/conv_mac_responder_if.sv
// rtl/conv_mac_responder_if.sv - sample/kernel input and result output channels of the convolution responder
interface conv_mac_responder_if #(
  parameter int LEN    = 4,
  parameter int DATA_W = 8,
  parameter int RES_W  = 2 * DATA_W + $clog2(LEN)
);
  logic [DATA_W-1:0]     in_data;
  logic [LEN*DATA_W-1:0] kernel;
  logic                  in_valid;
  logic                  in_ready;
  logic [RES_W-1:0]      result;
  logic                  out_valid;
  logic                  out_ready;

  // producer of samples and consumer of results
  modport master (
    output in_data, kernel, in_valid, out_ready,
    input  in_ready, result, out_valid
  );

  // the responder datapath
  modport slave (
    input  in_data, kernel, in_valid, out_ready,
    output in_ready, result, out_valid
  );
endinterface

// File: rtl/conv_mac_responder.sv
// rtl/conv_mac_responder.sv - sliding-window dot product computed serially with one multiplier
module conv_mac_responder #(
  parameter int LEN    = 4,
  parameter int DATA_W = 8,
  parameter int RES_W  = 2 * DATA_W + $clog2(LEN)
) (
  input logic                 clk,
  input logic                 rst,
  conv_mac_responder_if.slave bus
);
  localparam int IDX_W = $clog2(LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [DATA_W-1:0]   win_q  [LEN];
  logic [DATA_W-1:0]   win_d  [LEN];
  logic [DATA_W-1:0]   kern_q [LEN];
  logic [DATA_W-1:0]   kern_d [LEN];
  logic [RES_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic [2*DATA_W-1:0] prod;
  logic [RES_W-1:0]    sum;

  // Single shared multiplier: one tap per CALC cycle, product zero-extended
  // (or truncated, for a narrow RES_W) into the accumulator width.
  assign prod = {{DATA_W{1'b0}}, win_q[idx_q]} * {{DATA_W{1'b0}}, kern_q[idx_q]};
  assign sum  = acc_q + RES_W'(prod);

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;

  // Next-state logic: accept in IDLE, accumulate LEN taps, hold result until taken
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    kern_d      = kern_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          win_d[0] = bus.in_data;
          for (int k = 1; k < LEN; k++) begin
            win_d[k] = win_q[k-1];
          end
          for (int j = 0; j < LEN; j++) begin
            kern_d[j] = bus.kernel[j*DATA_W +: DATA_W];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = sum;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(LEN - 1)) begin
          result_d    = sum;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset wins over any accept or completion in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < LEN; k++) begin
        win_q[k]  <= '0;
        kern_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < LEN; k++) begin
        win_q[k]  <= win_d[k];
        kern_q[k] <= kern_d[k];
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_responder.sv
// tb/tb_conv_mac_responder.sv - self-checking bench for conv_mac_responder against a sample-history model
module tb_conv_mac_responder;
  localparam int LEN = 4;
  localparam int DW  = 8;
  localparam int RW  = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_mac_responder_if #(.LEN(LEN), .DATA_W(DW), .RES_W(RW)) bus ();

  conv_mac_responder #(.LEN(LEN), .DATA_W(DW), .RES_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int unsigned hist[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every accepted sample ever seen since reset; tap j multiplies the j-th most recent one.
  function automatic logic [RW-1:0] model_dot(input logic [LEN*DW-1:0] k);
    longint unsigned s;
    int n;
    s = 0;
    n = hist.size();
    for (int j = 0; j < LEN; j++) begin
      if (j < n) s += longint'(hist[n-1-j]) * longint'(k[j*DW +: DW]);
    end
    return RW'(s);
  endfunction

  function automatic logic [LEN*DW-1:0] pack(input int t0, input int t1, input int t2, input int t3);
    logic [7:0] a, b, c, d;
    a = 8'(t0); b = 8'(t1); c = 8'(t2); d = 8'(t3);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data = '0;
    bus.kernel = '0;
    tick();
    tick();
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic accept_beat(input logic [DW-1:0] d, input logic [LEN*DW-1:0] k, output bit ok);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    ok = 1'b0;
    if (bus.in_ready) begin
      bus.in_data = d;
      bus.kernel = k;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      hist.push_back(int'(d));
      ok = 1'b1;
    end
  endtask

  task automatic wait_valid(output bit ok, output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    ok = bus.out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'd77;
    bus.kernel = pack(5, 6, 7, 8);
    tick();
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_cmp++; if (bus.result !== 18'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", bus.result); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic test_single();
    bit ok;
    int cyc;
    logic [LEN*DW-1:0] k;
    logic [RW-1:0] exp;
    k = pack(1, 2, 3, 4);
    accept_beat(8'd3, k, ok);
    exp = model_dot(k);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %0b expected 1", ok); end
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_busy_ready: got %0b expected 0 at cycle %0d", bus.in_ready, cyc); end
      tick();
      cyc++;
    end
    n_cmp++; if (cyc !== LEN) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", cyc, LEN); end
    n_cmp++; if (bus.result !== 18'd3) begin n_fail++; $display("FAIL single_result: got %0d expected 3", bus.result); end
    n_cmp++; if (bus.result !== exp) begin n_fail++; $display("FAIL single_model: got %0d expected %0d", bus.result, exp); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_done_ready: got %0b expected 0", bus.in_ready); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid: got %0b expected 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_after_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_sequence();
    bit ok;
    int cyc;
    int fixed [4];
    logic [LEN*DW-1:0] k;
    logic [RW-1:0] exp;
    fixed = '{1, 4, 10, 20};
    do_reset();
    k = pack(1, 2, 3, 4);
    for (int i = 0; i < 4; i++) begin
      accept_beat(8'(i + 1), k, ok);
      exp = model_dot(k);
      wait_valid(ok, cyc);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %0b expected 1", i, ok); end
      n_cmp++; if (bus.result !== RW'(fixed[i])) begin n_fail++; $display("FAIL seq_result[%0d]: got %0d expected %0d", i, bus.result, fixed[i]); end
      n_cmp++; if (bus.result !== exp) begin n_fail++; $display("FAIL seq_model[%0d]: got %0d expected %0d", i, bus.result, exp); end
      tick();
    end
  endtask

  task automatic test_max();
    bit ok;
    int cyc;
    logic [LEN*DW-1:0] k;
    logic [RW-1:0] exp;
    do_reset();
    k = pack(255, 255, 255, 255);
    for (int i = 0; i < 4; i++) begin
      accept_beat(8'd255, k, ok);
      exp = model_dot(k);
      wait_valid(ok, cyc);
      n_cmp++; if (bus.result !== exp) begin n_fail++; $display("FAIL max_model[%0d]: got %0d expected %0d", i, bus.result, exp); end
      if (i == 3) begin
        n_cmp++; if (bus.result !== 18'd260100) begin n_fail++; $display("FAIL max_result: got %0d expected 260100", bus.result); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [LEN*DW-1:0] k;
    logic [RW-1:0] exp, held;
    bit hold_bad;
    bus.out_ready = 1'b0;
    k = LEN*DW'($urandom);
    accept_beat(8'($urandom), k, ok);
    exp = model_dot(k);
    wait_valid(ok, cyc);
    held = bus.result;
    n_cmp++; if (held !== exp) begin n_fail++; $display("FAIL bp_result: got %0d expected %0d", held, exp); end
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'($urandom);
      bus.kernel = LEN*DW'($urandom);
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== held) hold_bad = 1'b1;
    end
    n_cmp++; if (hold_bad !== 1'b0) begin n_fail++; $display("FAIL bp_hold: valid %0b ready %0b result %0d, required 1/0/%0d", bus.out_valid, bus.in_ready, bus.result, held); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b expected 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b expected 1", bus.in_ready); end
    k = pack(1, 1, 1, 1);
    accept_beat(8'd9, k, ok);
    exp = model_dot(k);
    wait_valid(ok, cyc);
    n_cmp++; if (bus.result !== exp) begin n_fail++; $display("FAIL bp_no_consume: got %0d expected %0d", bus.result, exp); end
    tick();
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    int cyc;
    bit seen;
    logic [LEN*DW-1:0] k;
    logic [RW-1:0] exp;
    accept_beat(8'($urandom_range(1, 255)), pack(7, 7, 7, 7), ok);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hist.delete();
    seen = 1'b0;
    for (int i = 0; i < LEN + 3; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %0b expected 0", seen); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %0b expected 1", bus.in_ready); end
    k = pack(2, 9, 9, 9);
    accept_beat(8'd5, k, ok);
    exp = model_dot(k);
    wait_valid(ok, cyc);
    n_cmp++; if (bus.result !== 18'd10) begin n_fail++; $display("FAIL abort_next_result: got %0d expected 10", bus.result); end
    n_cmp++; if (bus.result !== exp) begin n_fail++; $display("FAIL abort_next_model: got %0d expected %0d", bus.result, exp); end
    tick();
  endtask

  task automatic test_kernel_change();
    bit ok;
    int cyc;
    logic [LEN*DW-1:0] k;
    logic [RW-1:0] exp;
    k = pack($urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255));
    accept_beat(8'($urandom_range(1, 255)), k, ok);
    exp = model_dot(k);
    bus.kernel = '0;
    bus.in_data = '0;
    wait_valid(ok, cyc);
    n_cmp++; if (bus.result !== exp) begin n_fail++; $display("FAIL kchg_result: got %0d expected %0d", bus.result, exp); end
    n_cmp++; if (bus.result === 18'd0) begin n_fail++; $display("FAIL kchg_nonzero: got %0d expected nonzero", bus.result); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    int t_prev, t_now;
    bus.out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      accept_beat(8'($urandom), LEN*DW'($urandom), ok);
      t_now = cyc_cnt;
      if (i > 0) begin
        n_cmp++; if (t_now - t_prev !== LEN + 2) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, t_now - t_prev, LEN + 2); end
      end
      t_prev = t_now;
      wait_valid(ok, cyc);
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done_one_cycle[%0d]: got %0b expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int cyc;
    int stall;
    logic [LEN*DW-1:0] k;
    logic [RW-1:0] exp;
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      k = LEN*DW'($urandom);
      accept_beat(8'($urandom), k, ok);
      exp = model_dot(k);
      wait_valid(ok, cyc);
      n_cmp++; if (cyc !== LEN) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, cyc, LEN); end
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      n_cmp++; if (bus.result !== exp || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_result[%0d]: got %0d valid %0b expected %0d valid 1", i, bus.result, bus.out_valid, exp); end
      bus.out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data = '0;
    bus.kernel = '0;
    tick();
    test_reset();
    test_single();
    test_sequence();
    test_max();
    test_backpressure();
    test_reset_mid_calc();
    test_kernel_change();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
